// File: rtl/clock_ctrl.sv
// clock_ctrl: run/set sequencer for a cascaded hh:mm:ss BCD counter datapath.
// In RUN it forwards the 1 Hz tick as the seconds enable and chains the
// minute/hour enables through the counter carries with no latency. In the
// set states the increment button adjusts hours or minutes, the field being
// set blinks, and inactivity falls back to RUN.
// Optional build macro CLOCK_CTRL_AUTO_REPEAT_EN adds hold-to-repeat on the
// increment button (driven by inc_level).
module clock_ctrl #(
  parameter int SET_TIMEOUT  = 30,
  parameter int BLINK_DIV    = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_fast,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       inc_level,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic [1:0] set_mode,
  output logic       blink_min,
  output logic       blink_hour
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10,
    BAD      = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] tmo_cnt, tmo_nxt;
  logic [3:0] div_cnt, div_nxt;
  logic       phase, phase_nxt;
  logic       in_set;
  logic       rep_pulse;
  logic       inc_evt;

  assign in_set   = (state == SET_HOUR) || (state == SET_MIN);
  // mode button always wins over an increment in the same cycle
  assign inc_evt  = (inc_pulse | rep_pulse) & ~mode_pulse;
  assign set_mode = state;

`ifdef CLOCK_CTRL_AUTO_REPEAT_EN
  logic [7:0] dly_cnt;
  logic [7:0] rate_cnt;
  logic       armed;

  // Hold-to-repeat: wait REPEAT_DELAY fast ticks, then pulse every REPEAT_RATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt   <= '0;
      rate_cnt  <= '0;
      armed     <= 1'b0;
      rep_pulse <= 1'b0;
    end else if (!in_set || !inc_level || (state_nxt != state)) begin
      dly_cnt   <= '0;
      rate_cnt  <= '0;
      armed     <= 1'b0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (tick_fast) begin
        if (!armed) begin
          if (dly_cnt == 8'(REPEAT_DELAY - 1)) begin
            armed     <= 1'b1;
            rep_pulse <= 1'b1;
            rate_cnt  <= '0;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end else if (rate_cnt == 8'(REPEAT_RATE - 1)) begin
          rep_pulse <= 1'b1;
          rate_cnt  <= '0;
        end else begin
          rate_cnt <= rate_cnt + 8'd1;
        end
      end
    end
  end
`else
  // Without auto-repeat the held level and repeat timing are not consumed.
  logic [2:0] unused_repeat;
  assign unused_repeat = {inc_level, REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign rep_pulse     = 1'b0;
`endif

  // Counter enables are combinational so they line up with the carries.
  always_comb begin
    sec_inc  = 1'b0;
    min_inc  = 1'b0;
    hour_inc = 1'b0;
    case (state)
      RUN: begin
        sec_inc  = tick_1hz;
        min_inc  = tick_1hz & sec_carry;
        hour_inc = tick_1hz & sec_carry & min_carry;
      end
      SET_HOUR: hour_inc = inc_evt;
      SET_MIN:  min_inc  = inc_evt;
      default: ;
    endcase
  end

  // Next state, inactivity timeout and blink divider.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    div_nxt   = div_cnt;
    phase_nxt = phase;
    case (state)
      RUN: begin
        tmo_nxt   = '0;
        div_nxt   = '0;
        phase_nxt = 1'b0;
        if (mode_pulse) state_nxt = SET_HOUR;
      end
      SET_HOUR, SET_MIN: begin
        if (mode_pulse) begin
          if (state == SET_HOUR) state_nxt = SET_MIN;
          else                   state_nxt = RUN;
          tmo_nxt   = '0;
          div_nxt   = '0;
          phase_nxt = 1'b0;
        end else if (inc_evt) begin
          // keep digits solid and restart the idle count while adjusting
          tmo_nxt   = '0;
          div_nxt   = '0;
          phase_nxt = 1'b0;
        end else begin
          if (tick_fast) begin
            if (div_cnt == 4'(BLINK_DIV - 1)) begin
              div_nxt   = '0;
              phase_nxt = ~phase;
            end else begin
              div_nxt = div_cnt + 4'd1;
            end
          end
          if (tick_1hz) begin
            if (tmo_cnt == 6'(SET_TIMEOUT - 1)) begin
              state_nxt = RUN;
              tmo_nxt   = '0;
              div_nxt   = '0;
              phase_nxt = 1'b0;
            end else begin
              tmo_nxt = tmo_cnt + 6'd1;
            end
          end
        end
      end
      default: begin
        state_nxt = RUN;
        tmo_nxt   = '0;
        div_nxt   = '0;
        phase_nxt = 1'b0;
      end
    endcase
  end

  // FSM state plus registered blink flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      tmo_cnt    <= '0;
      div_cnt    <= '0;
      phase      <= 1'b0;
      blink_hour <= 1'b0;
      blink_min  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      div_cnt    <= div_nxt;
      phase      <= phase_nxt;
      blink_hour <= (state_nxt == SET_HOUR) & phase_nxt;
      blink_min  <= (state_nxt == SET_MIN) & phase_nxt;
    end
  end

endmodule
